breathe_leds: RTL and testbench
===============================

BREATHE_LEDS -- requirements
Module: breathe_leds

Interface
REQ-001 SHALL have parameter CH, default 16: number of LED channels.
REQ-002 SHALL have parameter W, default 8: PWM/duty width; M = 2^W-1 is full scale.
REQ-003 SHALL have parameter DIV, default 500_000: sys_clk cycles per brightness step (legal range >= 1).
REQ-004 SHALL have parameter STAGGER, default 16: per-channel phase offset in steps (used only under REQ-030).
REQ-005 sys_clk  in  1  sole clock; all state rising-edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 enable  in  1  1 = brightness pattern advances; 0 = pattern frozen, PWM keeps running.
REQ-008 mode  in  2  00 off, 01 triangle breathe, 10 sawtooth ramp, 11 hold at level.
REQ-009 level  in  W  duty used in hold mode.
REQ-010 LED  out  CH  registered PWM outputs, one per channel.
REQ-011 peak  out  1  registered one-cycle pulse when the pattern phase reaches M.

Function
REQ-012 Prescaler SHALL count 0..DIV-1 and wrap; step pulse when count = DIV-1 and enable = 1; prescaler holds when enable = 0.
REQ-013 Phase counter ph (W+1 bits) SHALL advance by 1 per step over 0..2M-1, wrapping 2M-1 -> 0.
REQ-014 peak SHALL assert for exactly one cycle, the cycle after ph becomes M.
REQ-015 Triangle pattern value SHALL be fold(p) = p when p <= M, else 2M-p.
REQ-016 Sawtooth pattern value SHALL be p >> 1 (range 0..M-1).
REQ-017 Target duty per channel: off -> 0; triangle -> fold(p_i); sawtooth -> p_i >> 1; hold -> level; p_i per REQ-030.
REQ-018 PWM counter SHALL count 0..M-1 and wrap (period M cycles), free-running regardless of enable and mode.
REQ-019 Per-channel duty registers SHALL load their targets only in the cycle the PWM counter wraps to 0, so no partial-period glitches occur.
REQ-020 LED[i] SHALL be registered (pwm_cnt < duty_i): duty 0 -> constantly low, duty M -> constantly high.
REQ-021 Input changes (mode, level) SHALL reach LED within 1 to M+1 cycles.
REQ-022 Mode changes SHALL NOT reset ph or the prescaler; the pattern resumes from the current phase.
REQ-023 DIV = 1 SHALL give one step per enabled cycle.

Reset
REQ-024 While rst_n = 0, LED, peak, prescaler, ph, PWM counter and all duty registers SHALL be 0 immediately, independent of sys_clk.
REQ-025 Assertion mid-ramp SHALL abort the pattern; after release ph restarts at 0.
REQ-026 First step after release SHALL occur DIV enabled cycles after the first sys_clk edge.

Configuration
REQ-030 Macro BREATHE_STAGGER_EN: when defined, p_i = (ph + i*STAGGER) mod 2M, computed at full width without overflow; when undefined, p_i = ph for every channel and all LED bits are identical.

Verification (CH=4, W=4 so M=15, DIV=2, STAGGER=4)
REQ-040 rst_n low mid-run -> LED=0, peak=0 same cycle; release, mode=11, level=15 -> LED=4'hF constant from the first PWM wrap (within 16 cycles).
REQ-041 mode=11, level=5 -> each LED high exactly 5 of every 15 cycles; change to level=0 mid-period -> current period finishes at 5, then LED stays 0.
REQ-042 mode=01, enable=1 from reset -> ph reaches 15 after 30 cycles, peak one cycle wide, ph wraps 29 -> 0 after 60 cycles, duty sequence 0..15..1.
REQ-043 enable=0 at ph=7 for 100 cycles -> ph and duty stay 7, LED keeps 7/15 duty; enable=1 -> ph=8 after 2 cycles.
REQ-044 BREATHE_STAGGER_EN defined, mode=01, ph=13 -> channel duties 13, 13 (fold 17), 9 (fold 21), 5 (fold 25); undefined -> all 13.
REQ-045 mode=10 across the ph wrap -> duty 14 then 0, with no LED pulse shorter than the new duty.

Source files
------------

// File: rtl/breathe_leds.sv
// breathe_leds: multi-channel PWM LED breathing / ramp / hold pattern generator.
// Define BREATHE_STAGGER_EN to offset each channel's pattern phase by STAGGER steps.
module breathe_leds #(
  parameter int CH      = 16,
  parameter int W       = 8,
  parameter int DIV     = 500_000,
  parameter int STAGGER = 16
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [1:0]    mode,
  input  logic [W-1:0]  level,
  output logic [CH-1:0] LED,
  output logic          peak
);

  localparam int M  = (1 << W) - 1;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [W:0]    PH_MID   = (W+1)'(M);
  localparam logic [W:0]    PH_LAST  = (W+1)'(2 * M - 1);
  localparam logic [W-1:0]  PWM_LAST = W'(M - 1);

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_TRI  = 2'b01,
    MODE_SAW  = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  logic [PW-1:0] pre_q, pre_d;
  logic [W:0]    ph_q, ph_d;
  logic [W-1:0]  pwm_q, pwm_d;
  logic          step, step_q, peak_q, pwm_wrap;
  logic [CH-1:0] led_q;
  logic [W:0]    chan_p;
  logic [W-1:0]  target [CH];
  logic [W-1:0]  duty_q [CH];

  // Above M the low W bits are p - 2^W, and 2M - p == (M-1) - (p - 2^W).
  function automatic logic [W-1:0] fold(input logic [W:0] p);
    return (p <= PH_MID) ? p[W-1:0] : PWM_LAST - p[W-1:0];
  endfunction

`ifdef BREATHE_STAGGER_EN
  function automatic logic [W:0] chan_phase(input logic [W:0] ph, input int idx);
    logic [W:0]   off;
    logic [W+1:0] sum;
    off = (W+1)'((longint'(idx) * longint'(STAGGER)) % longint'(2 * M));
    sum = {1'b0, ph} + {1'b0, off};
    return (sum >= (W+2)'(2 * M)) ? (W+1)'(sum - (W+2)'(2 * M)) : sum[W:0];
  endfunction
`endif

  // NOTE: every variable of an always_comb gets a default before any branch, so no latch can be inferred.
  always_comb begin
    pre_d    = pre_q;
    ph_d     = ph_q;
    step     = 1'b0;
    pwm_wrap = (pwm_q == PWM_LAST);
    pwm_d    = pwm_wrap ? '0 : pwm_q + 1'b1;
    if (enable) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        step  = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
    if (step) begin
      ph_d = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
    end
  end

  always_comb begin
    chan_p = '0;
    for (int i = 0; i < CH; i++) begin
      target[i] = '0;
`ifdef BREATHE_STAGGER_EN
      chan_p = chan_phase(ph_q, i);
`else
      chan_p = ph_q;
`endif
      case (mode_e'(mode))
        MODE_TRI:  target[i] = fold(chan_p);
        MODE_SAW:  target[i] = chan_p[W:1];
        MODE_HOLD: target[i] = level;
        default:   target[i] = '0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      ph_q   <= '0;
      pwm_q  <= '0;
      step_q <= 1'b0;
      peak_q <= 1'b0;
      led_q  <= '0;
      // NOTE: the duty array is reset too; LEDs must be dark right after reset, not after one PWM period.
      for (int i = 0; i < CH; i++) begin
        duty_q[i] <= '0;
      end
    end else begin
      pre_q  <= pre_d;
      ph_q   <= ph_d;
      pwm_q  <= pwm_d;
      step_q <= step;
      // Pulse only on the step that lands on M, not while frozen there.
      peak_q <= step_q && (ph_q == PH_MID);
      for (int i = 0; i < CH; i++) begin
        if (pwm_wrap) begin
          duty_q[i] <= target[i];
        end
        led_q[i] <= (pwm_q < duty_q[i]);
      end
    end
  end

  assign LED  = led_q;
  assign peak = peak_q;

endmodule

// File: tb/tb_breathe_leds.sv
// Self-checking bench for breathe_leds (CH=4, W=4, DIV=2 and DIV=1, STAGGER=4).
module tb_breathe_leds;

  localparam int CH = 4;
  localparam int M  = 15;
  localparam int HN = 512;
`ifdef BREATHE_STAGGER_EN
  localparam int TB_STAG = 4;
`else
  localparam int TB_STAG = 0;
`endif

  logic          sys_clk = 1'b0;
  logic          rst_n   = 1'b0;
  logic          enable  = 1'b0;
  logic [1:0]    mode    = 2'b00;
  logic [3:0]    level   = 4'd0;
  logic [CH-1:0] led, led1;
  logic          peak, peak1;

  breathe_leds #(.CH(CH), .W(4), .DIV(2), .STAGGER(4)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .level(level), .LED(led), .peak(peak)
  );

  breathe_leds #(.CH(CH), .W(4), .DIV(1), .STAGGER(4)) dut1 (
    .sys_clk(sys_clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .level(level), .LED(led1), .peak(peak1)
  );

  always #5 sys_clk = ~sys_clk;

  // Edge counter since reset release plus per-edge output history.
  int            cyc = 0;
  logic [CH-1:0] led_hist   [HN];
  logic          peak_hist  [HN];
  logic          peak1_hist [HN];

  always @(posedge sys_clk) begin
    if (!rst_n) begin
      cyc = 0;
    end else begin
      cyc = cyc + 1;
      #1;
      if (cyc < HN) begin
        led_hist[cyc]   = led;
        peak_hist[cyc]  = peak;
        peak1_hist[cyc] = peak1;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string name;
    int    start;
    int    duty [CH];
  } win_t;

  typedef struct {
    logic [1:0] mode;
    logic [3:0] level;
    int         duty;
  } vec_t;

  win_t sb [$];
  vec_t vecs [7];

  function automatic int tb_target(input logic [1:0] m, input int p, input int lvl);
    case (m)
      2'b01:   return (p > M) ? (2 * M - p) : p;
      2'b10:   return p / 2;
      2'b11:   return lvl;
      default: return 0;
    endcase
  endfunction

  task automatic expect_fixed(input string name, input int start, input int duty);
    win_t w;
    w.name  = name;
    w.start = start;
    for (int c = 0; c < CH; c++) w.duty[c] = duty;
    sb.push_back(w);
  endtask

  task automatic expect_pattern(input string name, input int start, input logic [1:0] m, input int ph);
    win_t w;
    w.name  = name;
    w.start = start;
    for (int c = 0; c < CH; c++) w.duty[c] = tb_target(m, (ph + c * TB_STAG) % (2 * M), 0);
    sb.push_back(w);
  endtask

  // One PWM period starting right after a wrap must be duty highs then lows.
  task automatic drain();
    win_t        w;
    logic [14:0] act, exp;
    while (sb.size() > 0) begin
      w = sb.pop_front();
      for (int c = 0; c < CH; c++) begin
        for (int j = 0; j < M; j++) begin
          act[j] = led_hist[w.start + j][c];
          exp[j] = (j < w.duty[c]);
        end
        check($sformatf("%s_ch%0d", w.name, c), act, exp);
      end
    end
  endtask

  function automatic int first_peak(input bit fast, input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      if ((fast ? peak1_hist[k] : peak_hist[k]) === 1'b1) return k;
    end
    return -1;
  endfunction

  function automatic int peak_count(input bit fast, input int lo, input int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++) begin
      if ((fast ? peak1_hist[k] : peak_hist[k]) === 1'b1) n++;
    end
    return n;
  endfunction

  task automatic reset_run(input logic [1:0] m, input logic [3:0] lvl, input logic en);
    @(negedge sys_clk);
    rst_n  = 1'b0;
    mode   = m;
    level  = lvl;
    enable = en;
    repeat (2) @(negedge sys_clk);
    check("reset_led", led, 0);
    check("reset_peak", peak, 0);
    check("reset_led_div1", led1, 0);
    rst_n = 1'b1;
  endtask

  task automatic run_to(input int k);
    while (cyc < k) @(negedge sys_clk);
  endtask

  initial begin
    int bad;

    vecs[0] = '{2'b11, 4'd0,  0};
    vecs[1] = '{2'b11, 4'd15, 15};
    vecs[2] = '{2'b11, 4'd5,  5};
    vecs[3] = '{2'b11, 4'd1,  1};
    vecs[4] = '{2'b11, 4'd14, 14};
    vecs[5] = '{2'b00, 4'd9,  0};
    vecs[6] = '{2'b11, 4'd8,  8};

    // Steady-state duty per mode/level.
    for (int v = 0; v < 7; v++) begin
      reset_run(vecs[v].mode, vecs[v].level, 1'b1);
      run_to(45);
      expect_fixed($sformatf("vec%0d_p1", v), 16, vecs[v].duty);
      expect_fixed($sformatf("vec%0d_p2", v), 31, vecs[v].duty);
      drain();
    end

    // Hold at full scale: dark until the first wrap, then solid.
    reset_run(2'b11, 4'd15, 1'b1);
    run_to(60);
    check("hold15_before_wrap", led_hist[15], 4'h0);
    check("hold15_first_period", led_hist[16], 4'hF);
    bad = 0;
    for (int k = 16; k <= 60; k++) if (led_hist[k] !== 4'hF) bad++;
    check("hold15_not_solid_cycles", bad, 0);
    check("hold15_live", led, 4'hF);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_led", led, 0);
    check("async_reset_led_div1", led1, 0);

    // Async reset must clear a live peak pulse immediately.
    reset_run(2'b01, 4'd0, 1'b1);
    run_to(31);
    check("peak_live", peak, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_peak", peak, 0);

    // Level change mid-period: current period completes, then dark.
    reset_run(2'b11, 4'd5, 1'b1);
    run_to(37);
    level = 4'd0;
    run_to(95);
    expect_fixed("lvl5_a", 16, 5);
    expect_fixed("lvl5_b", 31, 5);
    expect_fixed("lvl0_a", 46, 0);
    expect_fixed("lvl0_b", 61, 0);
    expect_fixed("lvl0_c", 76, 0);
    drain();

    // Triangle breathe from reset: peaks and folded duty sequence.
    reset_run(2'b01, 4'd0, 1'b1);
    run_to(200);
    check("tri_first_peak", first_peak(1'b0, 1, 200), 31);
    check("tri_peak_width", peak_hist[32], 0);
    check("tri_second_peak", first_peak(1'b0, 32, 200), 91);
    check("tri_peak_count", peak_count(1'b0, 1, 200), 3);
    check("div1_first_peak", first_peak(1'b1, 1, 200), 16);
    check("div1_peak_count", peak_count(1'b1, 1, 200), 7);
    for (int n = 1; n <= 12; n++) begin
      expect_pattern($sformatf("tri_w%0d", n), 15 * n + 1, 2'b01, ((15 * n - 1) / 2) % 30);
    end
    drain();

    // Freeze at ph=7, then resume.
    reset_run(2'b01, 4'd0, 1'b1);
    run_to(14);
    enable = 1'b0;
    run_to(114);
    enable = 1'b1;
    run_to(140);
    expect_pattern("frz_start", 31, 2'b01, 7);
    expect_pattern("frz_late", 106, 2'b01, 7);
    expect_pattern("frz_resume", 121, 2'b01, 9);
    drain();
    check("frz_peak_after_resume", first_peak(1'b0, 1, 140), 131);

    // Sawtooth across the phase wrap.
    reset_run(2'b10, 4'd0, 1'b1);
    run_to(95);
    for (int n = 1; n <= 5; n++) begin
      expect_pattern($sformatf("saw_w%0d", n), 15 * n + 1, 2'b10, ((15 * n - 1) / 2) % 30);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
